// File: rtl/pc_sequencer.sv
// Fetch sequencer: steers the PC register (hold/advance/redirect/boot load) and
// the instruction-memory request handshake, with interrupt entry/return and halt.
module pc_sequencer #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] IRQ_VEC  = PC_W'(8'hF0),
    parameter int unsigned     MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            boot_load,
    input  logic [PC_W-1:0] boot_addr,
    input  logic [PC_W-1:0] pc,
    output logic            imem_req,
    input  logic            imem_ack,
    output logic            fetch_valid,
    input  logic            hazard,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            reti,
    input  logic            halt_instr,
    input  logic            irq,
    output logic [PC_W-1:0] pc_next_val,
    output logic            pc_stall,
    output logic            pc_load_n,
    output logic [PC_W-1:0] pc_load_val,
    output logic [PC_W-1:0] epc,
    output logic            in_irq,
    output logic            halted,
    output logic            mem_timeout
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]      state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_nxt;
    logic [PC_W-1:0] epc_nxt;
    logic [PC_W-1:0] seq_pc;
    logic            in_irq_nxt, halted_nxt, timeout_nxt;

    // State and status registers; the load strobe is a bare flop so it cannot glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            epc         <= '0;
            in_irq      <= 1'b0;
            halted      <= 1'b0;
            mem_timeout <= 1'b0;
            pc_load_n   <= 1'b1;
            pc_load_val <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            epc         <= epc_nxt;
            in_irq      <= in_irq_nxt;
            halted      <= halted_nxt;
            mem_timeout <= timeout_nxt;
            pc_load_n   <= ~boot_load;
            if (boot_load) begin
                pc_load_val <= boot_addr;
            end
        end
    end

    // Non-interrupt successor: jump beats branch beats sequential.
    always_comb begin
        seq_pc = pc + PC_W'(1);
        if (jump) begin
            seq_pc = jump_target;
        end else if (branch_taken) begin
            seq_pc = branch_target;
        end
    end

    // Next-state and decoded outputs.
    always_comb begin
        state_nxt   = state;
        wait_nxt    = '0;
        epc_nxt     = epc;
        in_irq_nxt  = in_irq;
        halted_nxt  = halted;
        timeout_nxt = mem_timeout;
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        pc_stall    = 1'b1;
        pc_next_val = pc;

        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nxt = S_ISSUE;
                end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                    state_nxt   = S_HALT;
                    halted_nxt  = 1'b1;
                    timeout_nxt = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                fetch_valid = 1'b1;
                if (!hazard && !boot_load) begin
                    if (halt_instr) begin
                        state_nxt  = S_HALT;
                        halted_nxt = 1'b1;
                    end else begin
                        pc_stall  = 1'b0;
                        state_nxt = S_FETCH;
                        if (reti) begin
                            pc_next_val = epc;
                            in_irq_nxt  = 1'b0;
                        end else if (irq && !in_irq) begin
                            pc_next_val = IRQ_VEC;
                            epc_nxt     = seq_pc;
                            in_irq_nxt  = 1'b1;
                        end else begin
                            pc_next_val = seq_pc;
                        end
                    end
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Boot load overrides everything and returns to a clean idle.
        if (boot_load) begin
            state_nxt   = S_IDLE;
            wait_nxt    = '0;
            halted_nxt  = 1'b0;
            in_irq_nxt  = 1'b0;
            timeout_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal checks, plus a
// per-cycle comparison against a behavioural model of the fetch rules.
module tb_pc_sequencer;

    localparam int unsigned MAX_WAIT = 15;
    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_ISSUE = 2;
    localparam int M_HALT  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       boot_load = 1'b0;
    logic [7:0] boot_addr = 8'h00;
    logic [7:0] pc = 8'h00;
    logic       imem_ack = 1'b0;
    logic       hazard = 1'b0;
    logic       branch_taken = 1'b0;
    logic [7:0] branch_target = 8'h00;
    logic       jump = 1'b0;
    logic [7:0] jump_target = 8'h00;
    logic       reti = 1'b0;
    logic       halt_instr = 1'b0;
    logic       irq = 1'b0;

    logic       imem_req, fetch_valid, pc_stall, pc_load_n;
    logic       in_irq, halted, mem_timeout;
    logic [7:0] pc_next_val, pc_load_val, epc;

    int tests = 0;
    int fails = 0;

    pc_sequencer #(.PC_W(8), .IRQ_VEC(8'hF0), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .run(run), .boot_load(boot_load),
        .boot_addr(boot_addr), .pc(pc), .imem_req(imem_req), .imem_ack(imem_ack),
        .fetch_valid(fetch_valid), .hazard(hazard), .branch_taken(branch_taken),
        .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
        .reti(reti), .halt_instr(halt_instr), .irq(irq), .pc_next_val(pc_next_val),
        .pc_stall(pc_stall), .pc_load_n(pc_load_n), .pc_load_val(pc_load_val),
        .epc(epc), .in_irq(in_irq), .halted(halted), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // Stand-in for the PC register the sequencer controls.
    always @(posedge clk or negedge reset or negedge pc_load_n) begin
        if (!reset)          pc <= 8'h00;
        else if (!pc_load_n) pc <= pc_load_val;
        else if (!pc_stall)  pc <= pc_next_val;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model, checked and advanced on every falling edge.
    int         mode = M_IDLE;
    int         waited = 0;
    logic [7:0] m_epc = 8'h00, m_load_val = 8'h00;
    logic       m_in_irq = 1'b0, m_halted = 1'b0, m_timeout = 1'b0, m_load_n = 1'b1;

    always @(negedge clk) begin
        logic       e_req, e_fv, e_stall;
        logic [7:0] e_nxt, succ;
        bool_retire: begin end
        if (!reset) begin
            mode = M_IDLE; waited = 0; m_epc = 8'h00; m_load_val = 8'h00;
            m_in_irq = 1'b0; m_halted = 1'b0; m_timeout = 1'b0; m_load_n = 1'b1;
        end
        succ    = jump ? jump_target : (branch_taken ? branch_target : pc + 8'd1);
        e_req   = (mode == M_FETCH);
        e_fv    = (mode == M_ISSUE);
        e_stall = 1'b1;
        e_nxt   = pc;
        if (mode == M_ISSUE && !hazard && !boot_load && !halt_instr) begin
            e_stall = 1'b0;
            e_nxt   = reti ? m_epc : ((irq && !m_in_irq) ? 8'hF0 : succ);
        end
        check("imem_req", imem_req, e_req);
        check("fetch_valid", fetch_valid, e_fv);
        check("pc_stall", pc_stall, e_stall);
        check("pc_next_val", pc_next_val, e_nxt);
        check("pc_load_n", pc_load_n, m_load_n);
        check("pc_load_val", pc_load_val, m_load_val);
        check("epc", epc, m_epc);
        check("in_irq", in_irq, m_in_irq);
        check("halted", halted, m_halted);
        check("mem_timeout", mem_timeout, m_timeout);
        if (reset) begin
            m_load_n = !boot_load;
            if (boot_load) begin
                m_load_val = boot_addr;
                mode = M_IDLE; waited = 0;
                m_halted = 1'b0; m_in_irq = 1'b0; m_timeout = 1'b0;
            end else begin
                case (mode)
                    M_IDLE:  if (run) mode = M_FETCH;
                    M_FETCH: begin
                        if (imem_ack) begin
                            mode = M_ISSUE; waited = 0;
                        end else if (waited + 1 == MAX_WAIT) begin
                            mode = M_HALT; waited = 0; m_halted = 1'b1; m_timeout = 1'b1;
                        end else begin
                            waited++;
                        end
                    end
                    M_ISSUE: begin
                        if (!hazard) begin
                            if (halt_instr) begin
                                mode = M_HALT; m_halted = 1'b1;
                            end else begin
                                mode = M_FETCH;
                                if (reti) m_in_irq = 1'b0;
                                else if (irq && !m_in_irq) begin
                                    m_epc = succ; m_in_irq = 1'b1;
                                end
                            end
                        end
                    end
                    default: mode = M_HALT;
                endcase
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_issue();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (fetch_valid) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        check("issue_reached", 32'(ok), 32'd1);
    endtask

    task automatic do_boot(input logic [7:0] a, input logic keep_run);
        imem_ack = 1'b0;
        #1;
        if (fetch_valid) cyc();
        boot_load = 1'b1;
        boot_addr = a;
        run = keep_run;
        cyc();
        boot_load = 1'b0;
        #1;
        check("boot_load_n", pc_load_n, 1'b0);
        check("boot_load_val", pc_load_val, a);
        check("boot_pc", pc, a);
        check("boot_flags", {halted, in_irq, mem_timeout}, 3'b000);
        cyc();
        #1;
        check("boot_load_n_release", pc_load_n, 1'b1);
    endtask

    initial begin
        logic [7:0] p;
        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_pc_stall", pc_stall, 1'b1);
        check("rst_pc_load_n", pc_load_n, 1'b1);
        check("rst_epc", epc, 8'h00);
        reset = 1'b1;

        // Sequential fetch from 0 and wrap at FF.
        run = 1'b1; imem_ack = 1'b1;
        wait_issue();
        check("seq0_pc", pc, 8'h00);
        check("seq0_next", pc_next_val, 8'h01);
        check("seq0_stall", pc_stall, 1'b0);
        cyc(); #1;
        check("seq1_pc", pc, 8'h01);
        check("seq1_fetch_stall", pc_stall, 1'b1);
        wait_issue();
        check("seq1_next", pc_next_val, 8'h02);
        cyc();
        do_boot(8'hFE, 1'b1);
        imem_ack = 1'b1;
        wait_issue();
        check("wrap_fe_next", pc_next_val, 8'hFF);
        cyc();
        wait_issue();
        check("wrap_ff_pc", pc, 8'hFF);
        check("wrap_ff_next", pc_next_val, 8'h00);
        cyc();

        // Priority: irq over jump over branch; no nesting; reti returns.
        do_boot(8'h10, 1'b1);
        imem_ack = 1'b1;
        wait_issue();
        check("prio_pc", pc, 8'h10);
        jump = 1'b1; jump_target = 8'h40; branch_taken = 1'b1; branch_target = 8'h20; irq = 1'b1;
        #1;
        check("prio_next", pc_next_val, 8'hF0);
        cyc();
        jump = 1'b0; branch_taken = 1'b0;
        #1;
        check("prio_in_irq", in_irq, 1'b1);
        check("prio_epc", epc, 8'h40);
        wait_issue();
        check("nest_pc", pc, 8'hF0);
        check("nest_next", pc_next_val, 8'hF1);
        irq = 1'b0;
        cyc();
        wait_issue();
        reti = 1'b1;
        #1;
        check("reti_next", pc_next_val, 8'h40);
        cyc();
        reti = 1'b0;
        #1;
        check("reti_in_irq", in_irq, 1'b0);

        // Hazard holds ISSUE for three cycles, then one advance.
        wait_issue();
        hazard = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hz_stall", pc_stall, 1'b1);
            check("hz_fv", fetch_valid, 1'b1);
            cyc();
        end
        hazard = 1'b0;
        #1;
        check("hz_release_stall", pc_stall, 1'b0);
        p = pc;
        cyc(); #1;
        check("hz_advance_pc", pc, p + 8'd1);

        // Memory timeout after MAX_WAIT unacknowledged FETCH cycles.
        wait_issue();
        imem_ack = 1'b0;
        cyc();
        repeat (MAX_WAIT - 1) cyc();
        #1;
        check("to_last_req", imem_req, 1'b1);
        check("to_last_halted", halted, 1'b0);
        cyc(); #1;
        check("to_halted", halted, 1'b1);
        check("to_flag", mem_timeout, 1'b1);
        check("to_req", imem_req, 1'b0);
        repeat (3) cyc();
        check("halt_ignores_run", halted, 1'b1);

        // Halt instruction at 33, then boot to 80.
        do_boot(8'h33, 1'b1);
        imem_ack = 1'b1;
        wait_issue();
        check("hi_pc", pc, 8'h33);
        halt_instr = 1'b1;
        #1;
        check("hi_next", pc_next_val, 8'h33);
        check("hi_stall", pc_stall, 1'b1);
        cyc();
        halt_instr = 1'b0;
        repeat (3) cyc();
        check("hi_hold_pc", pc, 8'h33);
        check("hi_halted", halted, 1'b1);
        check("hi_req", imem_req, 1'b0);
        do_boot(8'h80, 1'b0);
        #1;
        check("boot_idle_req", imem_req, 1'b0);

        // Ack on the final permitted wait cycle still issues.
        run = 1'b1; imem_ack = 1'b0;
        cyc();
        repeat (MAX_WAIT - 1) cyc();
        imem_ack = 1'b1;
        cyc(); #1;
        check("late_ack_issue", fetch_valid, 1'b1);
        check("late_ack_halted", halted, 1'b0);

        // Reset in the middle of a fetch.
        imem_ack = 1'b0;
        cyc(); cyc();
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_req", imem_req, 1'b0);
        check("mid_rst_stall", pc_stall, 1'b1);
        check("mid_rst_load_n", pc_load_n, 1'b1);
        check("mid_rst_load_val", pc_load_val, 8'h00);
        check("mid_rst_epc", epc, 8'h00);
        repeat (2) cyc();
        reset = 1'b1;
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
